// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C slave address counter.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam int BYTE_IDX_W = 3;

    // Number of bytes needed to carry an address of the given width.
    function automatic int addr_bytes(input int addr_w);
        return (addr_w + 7) / 8;
    endfunction

endpackage

// File: rtl/i2c_addr_incr.sv
// Next-address computation: page-wrapped increment in write mode, linear
// wrap in read mode. Purely combinational.
module i2c_addr_incr
    import i2c_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int PAGE_W = 6
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_mode,
    output logic [ADDR_W-1:0] addr_next,
    output logic              wrap
);

    // Mask form keeps PAGE_W == ADDR_W legal without a zero-width slice.
    localparam logic [ADDR_W-1:0] PAGE_MASK = {ADDR_W{1'b1}} >> (ADDR_W - PAGE_W);

    logic [ADDR_W-1:0] addr_plus1;

    assign addr_plus1 = addr + ADDR_W'(1);

    // Select wrap domain by transfer direction.
    always_comb begin
        addr_next = addr_plus1;
        wrap      = &addr;
        if (wr_mode) begin
            addr_next = (addr & ~PAGE_MASK) | (addr_plus1 & PAGE_MASK);
            wrap      = ((addr & PAGE_MASK) == PAGE_MASK);
        end
    end

endmodule

// File: rtl/i2c_addr_counter_p.sv
// Parametrised I2C slave memory-address counter.
//
//  state  | meaning
//  IDLE   | no transfer; committed address held for current-address reads
//  LOAD   | after START; collecting word-address bytes MSB first
//  ACTIVE | address committed; data bytes advance it
module i2c_addr_counter_p
    import i2c_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int PAGE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  load_byte,
    input  logic [7:0]            shift_data,
    input  logic                  incr,
    input  logic                  wr_mode,
    output logic [ADDR_W-1:0]     addr,
    output logic                  addr_valid,
    output logic [BYTE_IDX_W-1:0] byte_idx,
    output logic                  rollover,
    output logic                  seq_err
);

    localparam int ADDR_BYTES = addr_bytes(ADDR_W);

    if (ADDR_W < 1 || ADDR_W > 32) begin : g_bad_addr_w
        $error("ADDR_W must be within 1..32");
    end
    if (PAGE_W < 1 || PAGE_W > ADDR_W) begin : g_bad_page_w
        $error("PAGE_W must be within 1..ADDR_W");
    end

    state_t state, state_d;

    logic [ADDR_W-1:0]     staging, staging_d, staging_shift;
    logic [ADDR_W-1:0]     addr_d, addr_inc;
    logic                  addr_valid_d, rollover_d, seq_err_d, inc_wrap;
    logic [BYTE_IDX_W-1:0] byte_idx_d, byte_idx_inc;
    logic                  load_ok, load_last, incr_ok;

    i2c_addr_incr #(
        .ADDR_W (ADDR_W),
        .PAGE_W (PAGE_W)
    ) u_incr (
        .addr      (addr),
        .wr_mode   (wr_mode),
        .addr_next (addr_inc),
        .wrap      (inc_wrap)
    );

    // First-byte bits above ADDR_W fall off through the shift and size cast.
    assign staging_shift = (staging << 8) | ADDR_W'(shift_data);
    assign byte_idx_inc  = byte_idx + BYTE_IDX_W'(1);
    assign load_ok       = (state == LOAD);
    assign load_last     = load_ok && (byte_idx_inc == BYTE_IDX_W'(ADDR_BYTES));
    // INCR in LOAD before any address byte is a current-address read.
    assign incr_ok       = (state == ACTIVE) ||
                           (state == LOAD && byte_idx == '0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next state, strobe priority START > STOP > LOAD_BYTE > INCR.
    always_comb begin
        state_d = state;
        if (start)                      state_d = LOAD;
        else if (stop)                  state_d = IDLE;
        else if (load_byte) begin
            if (load_last)              state_d = ACTIVE;
        end
        else if (incr && incr_ok)       state_d = ACTIVE;
    end

    // Next values of the datapath and output registers, same priority.
    always_comb begin
        addr_d       = addr;
        staging_d    = staging;
        addr_valid_d = addr_valid;
        byte_idx_d   = byte_idx;
        rollover_d   = 1'b0;
        seq_err_d    = 1'b0;
        if (start) begin
            staging_d    = '0;
            byte_idx_d   = '0;
            addr_valid_d = 1'b0;
        end else if (stop) begin
            byte_idx_d   = '0;
            addr_valid_d = 1'b0;
        end else if (load_byte) begin
            if (load_ok) begin
                staging_d  = staging_shift;
                byte_idx_d = byte_idx_inc;
                if (load_last) begin
                    addr_d       = staging_shift;
                    addr_valid_d = 1'b1;
                end
            end else begin
                seq_err_d = 1'b1;
            end
        end else if (incr) begin
            if (incr_ok) begin
                addr_d       = addr_inc;
                addr_valid_d = 1'b1;
                rollover_d   = inc_wrap;
            end else begin
                seq_err_d = 1'b1;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr       <= '0;
            staging    <= '0;
            addr_valid <= 1'b0;
            byte_idx   <= '0;
            rollover   <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            addr       <= addr_d;
            staging    <= staging_d;
            addr_valid <= addr_valid_d;
            byte_idx   <= byte_idx_d;
            rollover   <= rollover_d;
            seq_err    <= seq_err_d;
        end
    end

endmodule

// File: doc/i2c_addr_counter_p.md
# i2c_addr_counter_p

Parametrised memory-address counter for the I2C slave datapath, the next generation of the fixed 16-bit address counter. It assembles a multi-byte word address from bytes delivered by the shift register and holds it across STOP for current-address reads. It auto-increments after each data byte: page-wrapped in write mode, linear-wrapped in read mode. It sits between the byte shift register/control FSM and the memory array address port, and runs on the system clock with strobed inputs rather than edge-triggered on control pulses.

## Interface
- ADDR_W, 16: address width in bits, 1..32; ADDR_BYTES = ceil(ADDR_W/8) bytes are loaded per address phase.
- PAGE_W, 6: page offset width (2^PAGE_W-byte write page), 1..ADDR_W.
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  one-cycle strobe: START or repeated START detected.
- STOP  input  1  one-cycle strobe: STOP detected.
- LOAD_BYTE  input  1  one-cycle strobe: SHIFT_DATA holds an address byte.
- SHIFT_DATA  input  8  byte from shift register, MSB-first address order.
- INCR  input  1  one-cycle strobe: a data byte was transferred, so advance the address.
- WR_MODE  input  1  1 = write transfer (page wrap), 0 = read (linear wrap); sampled with INCR.
- ADDR  output  ADDR_W  committed memory address.
- ADDR_VALID  output  1  committed address is usable for the current transfer.
- BYTE_IDX  output  3  address bytes received in the current load phase.
- ROLLOVER  output  1  one-cycle pulse: the last INCR wrapped (page or array).
- SEQ_ERR  output  1  one-cycle pulse: a strobe was illegal in the current state.

## Operation
- States: IDLE, LOAD, ACTIVE.
- Reset: state IDLE. ADDR=0, staging=0, ADDR_VALID=0, BYTE_IDX=0, ROLLOVER=0, SEQ_ERR=0.
- Per-cycle strobe priority: RST > START > STOP > LOAD_BYTE > INCR. Lower-priority strobes in the same cycle are dropped without SEQ_ERR.
- START, from any state: go to LOAD, BYTE_IDX=0, staging=0, ADDR_VALID=0. ADDR is not cleared.
- STOP, from any state: go to IDLE, BYTE_IDX=0, ADDR_VALID=0. ADDR is retained, so a partially loaded address is discarded.
- LOAD_BYTE in LOAD: staging = (staging<<8 | SHIFT_DATA) truncated to ADDR_W, then BYTE_IDX+1.
  - On the ADDR_BYTES-th byte, ADDR = new staging value, ADDR_VALID=1, go to ACTIVE.
  - Bits above ADDR_W in the first byte are discarded.
- LOAD_BYTE in IDLE or ACTIVE: no effect, SEQ_ERR pulse. In ACTIVE these are data bytes, so this is expected to be unused.
- INCR in ACTIVE: advance ADDR.
- INCR in LOAD with BYTE_IDX=0 (current-address read): advance ADDR, ADDR_VALID=1, go to ACTIVE.
- INCR in LOAD with BYTE_IDX>0, or in IDLE: no effect, SEQ_ERR pulse.
- Advance, WR_MODE=1: ADDR[PAGE_W-1:0] +1 modulo 2^PAGE_W, upper bits unchanged. ROLLOVER when the offset goes from all-ones to 0.
- Advance, WR_MODE=0: ADDR +1 modulo 2^ADDR_W. ROLLOVER when ADDR goes from all-ones to 0.
- If PAGE_W=ADDR_W, both modes behave identically.

## Timing
- All outputs are registered and change on the CLK edge that samples the strobe; effect is visible the next cycle.
- Address load latency: ADDR is updated on the same edge as the final LOAD_BYTE.
- ROLLOVER and SEQ_ERR are high for exactly one cycle. Back-to-back strobes every cycle are supported.
- RST mid-load or mid-transfer forces reset values asynchronously. The first strobe is honoured on the first edge after RST deasserts.
- Strobes are assumed synchronous to CLK; synchronisation of SCL/SDA-derived events happens upstream.

## Structure
- Package i2c_pkg holds:
  - the state typedef (IDLE/LOAD/ACTIVE);
  - the function addr_bytes(ADDR_W);
  - the localparam for BYTE_IDX width (3).
- Sub-module i2c_addr_incr (combinational) takes ADDR and WR_MODE and returns the next address and the wrap flag. The top module keeps the FSM, staging register, and output registers.
- Elaboration-time checks: 1<=ADDR_W<=32, 1<=PAGE_W<=ADDR_W.

## Test plan
- Default params: START, LOAD_BYTE 0x12, LOAD_BYTE 0x34, then 3×INCR with WR_MODE=0 → ADDR 0x1234, then 0x1237. ADDR_VALID rises with the 2nd byte, and BYTE_IDX reads 0,1,2.
- Page wrap: load 0x103E, then 3×INCR with WR_MODE=1 → 0x103F, 0x1000 (ROLLOVER pulse), 0x1001. Bits [15:6] are never changed.
- Linear wrap: load 0xFFFF, INCR with WR_MODE=0 → ADDR 0x0000 with ROLLOVER. With ADDR_W=10, load 0xFF,0xFF → ADDR 0x3FF.
- Current-address read: load 0x0050, STOP, START, INCR → ADDR 0x0051, state ACTIVE, no SEQ_ERR.
- Aborted load: ADDR 0x0050, START, LOAD_BYTE 0xAA, STOP → ADDR stays 0x0050. A further INCR in IDLE gives a SEQ_ERR pulse and ADDR is unchanged.
- Priority/reset: START and INCR in the same cycle → LOAD state, ADDR unchanged. RST asserted mid-load → all outputs 0 immediately.
